// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback for
// lw, sw, R-type, I-ALU, beq and jal; traps unsupported encodings and counts retired instructions.
module mc_control_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned ST_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [ST_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_e;

    state_e     state_q, state_d;
    logic       funct_ok_c;
    logic [2:0] alu_funct_c;
    logic       pc_update_c, branch_c, ir_write_c, mem_write_c, reg_write_c;
    logic       retire_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    assign funct_ok_c = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = funct_ok_c ? S_EXECR : S_ILLEGAL;
                    OP_I:         state_d = funct_ok_c ? S_EXECI : S_ILLEGAL;
                    OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // ALU operation selected by funct fields for R/I execute
    always_comb begin
        alu_funct_c = ALU_ADD;
        case (funct3)
            3'b000:  alu_funct_c = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b110:  alu_funct_c = ALU_OR;
            3'b111:  alu_funct_c = ALU_AND;
            default: alu_funct_c = ALU_ADD;
        endcase
    end

    // Output decode from state
    always_comb begin
        pc_update_c = 1'b0;
        branch_c    = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                ir_write_c  = mem_ready;
                pc_update_c = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct_c;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct_c;
            end
            S_ALUWB:    reg_write_c = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                branch_c   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                pc_update_c = 1'b1;
            end
            S_ILLEGAL:  illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    // Enables are gated by reset so an abandoned instruction never writes
    assign PCWrite  = rst & (pc_update_c | (branch_c & zero));
    assign IRWrite  = rst & ir_write_c;
    assign MemWrite = rst & mem_write_c;
    assign RegWrite = rst & reg_write_c;

    assign retire_c = (state_d == S_FETCH) &&
                      ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                       (state_q == S_ALUWB) || (state_q == S_BEQ));

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          instret <= '0;
        else if (retire_c) instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: directed instruction sequences push the expected
// per-cycle control word; a negedge monitor pops and compares.
module tb_mc_control_unit;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]       ALUControl;
    logic [CNT_W-1:0] instret;

    mc_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [16:0]      c;
        logic [CNT_W-1:0] n;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [1:0]  imm_e;
    logic [16:0] act;

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, RegWrite, illegal};

    // {pcw, adr, mw, irw, rs, srca, srcb, imm, alu, rw, ill}
    function automatic logic [16:0] ctl(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic [1:0] rs,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [2:0] alu, input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm_e, alu, rw, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic r);
        return ctl(r, 0, 0, r, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    endfunction
    function automatic logic [16:0] e_decode();  return ctl(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0); endfunction
    function automatic logic [16:0] e_memadr();  return ctl(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0); endfunction
    function automatic logic [16:0] e_memread(); return ctl(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic logic [16:0] e_memwb();   return ctl(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,0); endfunction
    function automatic logic [16:0] e_memwr();   return ctl(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic logic [16:0] e_execr(input logic [2:0] a); return ctl(0,0,0,0,2'b00,2'b10,2'b00,a,0,0); endfunction
    function automatic logic [16:0] e_execi(input logic [2:0] a); return ctl(0,0,0,0,2'b00,2'b10,2'b01,a,0,0); endfunction
    function automatic logic [16:0] e_aluwb();   return ctl(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0); endfunction
    function automatic logic [16:0] e_beq(input logic z); return ctl(z,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0); endfunction
    function automatic logic [16:0] e_jal();     return ctl(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0); endfunction
    function automatic logic [16:0] e_ill();     return ctl(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1); endfunction

    // Inputs must already be driven; check happens at the following negedge
    task automatic step(input string nm, input logic [16:0] c, input logic [CNT_W-1:0] n);
        exp_t e;
        e.nm = nm; e.c = c; e.n = n;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [1:0] imm);
        op = o; funct3 = f3; funct7b5 = f7; imm_e = imm;
    endtask

    // Monitor: compare control word and instret every cycle an expectation is pending
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (act !== e.c) begin
                n_bad++;
                $display("FAIL %s ctl: got %b want %b", e.nm, act, e.c);
            end
            n_vec++;
            if (instret !== e.n) begin
                n_bad++;
                $display("FAIL %s instret: got %0d want %0d", e.nm, instret, e.n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);
        @(posedge clk); #1;
        step("reset_hold", e_fetch(0), 0);
        step("reset_hold2", e_fetch(0), 0);
        rst = 1'b1;

        // add
        step("add_fetch", e_fetch(1), 0);
        step("add_decode", e_decode(), 0);
        step("add_exec", e_execr(3'b000), 0);
        step("add_wb", e_aluwb(), 0);
        // sub
        set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
        step("sub_fetch", e_fetch(1), 1);
        step("sub_decode", e_decode(), 1);
        step("sub_exec", e_execr(3'b001), 1);
        step("sub_wb", e_aluwb(), 1);
        // addi with funct7b5 set stays add
        set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
        step("addi_fetch", e_fetch(1), 2);
        step("addi_decode", e_decode(), 2);
        step("addi_exec", e_execi(3'b000), 2);
        step("addi_wb", e_aluwb(), 2);
        // ori
        set_instr(7'b0010011, 3'b110, 1'b0, 2'b00);
        step("ori_fetch", e_fetch(1), 3);
        step("ori_decode", e_decode(), 3);
        step("ori_exec", e_execi(3'b011), 3);
        step("ori_wb", e_aluwb(), 3);
        // and
        set_instr(7'b0110011, 3'b111, 1'b0, 2'b00);
        step("and_fetch", e_fetch(1), 4);
        step("and_decode", e_decode(), 4);
        step("and_exec", e_execr(3'b010), 4);
        step("and_wb", e_aluwb(), 4);

        // lw with a stalled fetch and 3 stalled read cycles
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        mem_ready = 1'b0;
        step("lw_fetch_wait", e_fetch(0), 5);
        mem_ready = 1'b1;
        step("lw_fetch", e_fetch(1), 5);
        step("lw_decode", e_decode(), 5);
        step("lw_memadr", e_memadr(), 5);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_read_wait", e_memread(), 5);
        mem_ready = 1'b1;
        step("lw_read", e_memread(), 5);
        step("lw_wb", e_memwb(), 5);

        // sw with one stalled write cycle
        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step("sw_fetch", e_fetch(1), 6);
        step("sw_decode", e_decode(), 6);
        step("sw_memadr", e_memadr(), 6);
        mem_ready = 1'b0;
        step("sw_write_wait", e_memwr(), 6);
        mem_ready = 1'b1;
        step("sw_write", e_memwr(), 6);

        // beq taken then not taken; zero high in decode must not leak to PCWrite
        set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
        zero = 1'b1;
        step("beqt_fetch", e_fetch(1), 7);
        step("beqt_decode", e_decode(), 7);
        step("beqt_exec", e_beq(1), 7);
        zero = 1'b0;
        step("beqn_fetch", e_fetch(1), 8);
        step("beqn_decode", e_decode(), 8);
        step("beqn_exec", e_beq(0), 8);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        step("jal_fetch", e_fetch(1), 9);
        step("jal_decode", e_decode(), 9);
        step("jal_exec", e_jal(), 9);
        step("jal_wb", e_aluwb(), 9);

        // reset in the middle of a stalled store
        set_instr(7'b0100011, 3'b000, 1'b0, 2'b01);
        step("sw2_fetch", e_fetch(1), 10);
        step("sw2_decode", e_decode(), 10);
        step("sw2_memadr", e_memadr(), 10);
        mem_ready = 1'b0;
        step("sw2_write_wait", e_memwr(), 10);
        rst = 1'b0;
        step("sw2_reset", e_fetch(0), 0);
        rst = 1'b1;

        // unknown opcode traps and stays trapped
        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
        mem_ready = 1'b1; zero = 1'b1;
        step("ill_fetch", e_fetch(1), 0);
        step("ill_decode", e_decode(), 0);
        for (int i = 0; i < 20; i++) step("ill_hold", e_ill(), 0);
        rst = 1'b0;
        step("ill_reset", e_fetch(0), 0);
        rst = 1'b1;

        // R-type with unsupported funct3 traps too
        set_instr(7'b0110011, 3'b001, 1'b0, 2'b00);
        zero = 1'b0;
        step("rbad_fetch", e_fetch(1), 0);
        step("rbad_decode", e_decode(), 0);
        step("rbad_trap", e_ill(), 0);
        step("rbad_hold", e_ill(), 0);

        // beq with funct3 != 000 traps
        rst = 1'b0;
        step("beqbad_reset", e_fetch(0), 0);
        rst = 1'b1;
        set_instr(7'b1100011, 3'b001, 1'b0, 2'b10);
        step("beqbad_fetch", e_fetch(1), 0);
        step("beqbad_decode", e_decode(), 0);
        step("beqbad_trap", e_ill(), 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
